// File: rtl/clk_gate_ctrl_pkg.sv
// rtl/clk_gate_ctrl_pkg.sv - shared types and constants for the clock-gate controller
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } cg_state_e;

    localparam int SYNC_LAT_DEFAULT = 3;

endpackage

// File: rtl/clk_gate_ctrl_ch.sv
// rtl/clk_gate_ctrl_ch.sv - one clock domain's gate FSM with idle counter
module clk_gate_ctrl_ch
    import clk_gate_ctrl_pkg::*;
#(
    parameter int IDLE_CNT_W = 8,
    parameter int SYNC_LAT   = SYNC_LAT_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  force_on_i,
    input  logic                  auto_en_i,
    input  logic                  wake_req_i,
    input  logic                  idle_i,
    input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
    output logic                  gate_en_o,
    output logic                  active_o,
    output logic                  off_o
);

    localparam logic [3:0]            LAT_M1  = 4'(SYNC_LAT - 1);
    localparam logic [IDLE_CNT_W-1:0] CNT_ONE = IDLE_CNT_W'(1);

    cg_state_e             state;
    logic [3:0]            lat_cnt;
    logic [IDLE_CNT_W-1:0] idle_cnt;
    logic                  wake;
    logic                  qualify;
    logic [IDLE_CNT_W-1:0] thresh_m1;

    always_comb begin
        wake      = force_on_i | wake_req_i;
        qualify   = auto_en_i & idle_i & ~force_on_i & ~wake_req_i & (idle_thresh_i != '0);
        thresh_m1 = idle_thresh_i - CNT_ONE;
    end

    // Outputs follow the registered state one cycle later, so the gate
    // enable rises the edge after WAKE is entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_OFF;
            lat_cnt   <= '0;
            idle_cnt  <= '0;
            gate_en_o <= 1'b0;
            active_o  <= 1'b0;
            off_o     <= 1'b1;
        end else begin
            gate_en_o <= (state == ST_WAKE) || (state == ST_ON);
            active_o  <= (state == ST_ON);
            off_o     <= (state == ST_OFF);
            case (state)
                ST_OFF: begin
                    if (wake) begin
                        state   <= ST_WAKE;
                        lat_cnt <= LAT_M1;
                    end
                end
                ST_WAKE: begin
                    if (lat_cnt == 4'd0) state <= ST_ON;
                    else                 lat_cnt <= lat_cnt - 4'd1;
                end
                ST_ON: begin
                    if (!qualify) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == thresh_m1) begin
                        state    <= ST_DRAIN;
                        idle_cnt <= '0;
                        lat_cnt  <= LAT_M1;
                    end else if (idle_cnt != '1) begin
                        // Saturate: a lowered threshold must not let the count wrap.
                        idle_cnt <= idle_cnt + CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (lat_cnt == 4'd0) state <= ST_OFF;
                    else                 lat_cnt <= lat_cnt - 4'd1;
                end
                default: state <= ST_OFF;
            endcase
        end
    end

endmodule

// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - array of per-domain clock-gate FSMs plus all-off flag
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int IDLE_CNT_W  = 8,
    parameter int SYNC_LAT    = SYNC_LAT_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_DOMAINS-1:0] force_on_i,
    input  logic [NUM_DOMAINS-1:0] auto_en_i,
    input  logic [NUM_DOMAINS-1:0] wake_req_i,
    input  logic [NUM_DOMAINS-1:0] idle_i,
    input  logic [IDLE_CNT_W-1:0]  idle_thresh_i,
    output logic [NUM_DOMAINS-1:0] gate_en_o,
    output logic [NUM_DOMAINS-1:0] active_o,
    output logic                   all_off_o
);

    logic [NUM_DOMAINS-1:0] ch_off;

    for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_ch
        clk_gate_ctrl_ch #(
            .IDLE_CNT_W (IDLE_CNT_W),
            .SYNC_LAT   (SYNC_LAT)
        ) u_ch (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .force_on_i    (force_on_i[d]),
            .auto_en_i     (auto_en_i[d]),
            .wake_req_i    (wake_req_i[d]),
            .idle_i        (idle_i[d]),
            .idle_thresh_i (idle_thresh_i),
            .gate_en_o     (gate_en_o[d]),
            .active_o      (active_o[d]),
            .off_o         (ch_off[d])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) all_off_o <= 1'b1;
        else       all_off_o <= &ch_off;
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - directed self-checking bench for clk_gate_ctrl
module tb_clk_gate_ctrl;

    localparam int ND = 4;
    localparam int IW = 8;
    localparam int SL = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [ND-1:0] force_on, auto_en, wake_req, idle;
    logic [IW-1:0] thresh;
    logic [ND-1:0] gate_en, active;
    logic          all_off;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_gate_ctrl #(
        .NUM_DOMAINS (ND),
        .IDLE_CNT_W  (IW),
        .SYNC_LAT    (SL)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .force_on_i    (force_on),
        .auto_en_i     (auto_en),
        .wake_req_i    (wake_req),
        .idle_i        (idle),
        .idle_thresh_i (thresh),
        .gate_en_o     (gate_en),
        .active_o      (active),
        .all_off_o     (all_off)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wake_domain(input int d);
        wake_req[d] = 1'b1;
        step(1);
        wake_req[d] = 1'b0;
        step(4);
        checks++;
        if (active[d] !== 1'b1) begin
            errors++;
            $display("FAIL wake_domain%0d active: got %b expected 1", d, active[d]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        checks++;
        if (gate_en !== '0) begin
            errors++;
            $display("FAIL reset gate_en: got %b expected 0000", gate_en);
        end
        checks++;
        if (active !== '0) begin
            errors++;
            $display("FAIL reset active: got %b expected 0000", active);
        end
        checks++;
        if (all_off !== 1'b1) begin
            errors++;
            $display("FAIL reset all_off: got %b expected 1", all_off);
        end
        rst = 1'b0;
    endtask

    task automatic test_wake_latency;
        logic eg, ea, eo;
        wake_req[0] = 1'b1;
        step(1);
        wake_req[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            eg = (k >= 1);
            ea = (k >= 1 + SL);
            eo = (k < 2);
            checks++;
            if (gate_en[0] !== eg) begin
                errors++;
                $display("FAIL wake_latency gate_en k=%0d: got %b expected %b", k, gate_en[0], eg);
            end
            checks++;
            if (active[0] !== ea) begin
                errors++;
                $display("FAIL wake_latency active k=%0d: got %b expected %b", k, active[0], ea);
            end
            checks++;
            if (all_off !== eo) begin
                errors++;
                $display("FAIL wake_latency all_off k=%0d: got %b expected %b", k, all_off, eo);
            end
            step(1);
        end
    endtask

    task automatic test_idle_drain;
        logic eg;
        wake_domain(1);
        auto_en[1] = 1'b1;
        thresh     = 8'd5;
        idle[1]    = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            eg = (k <= 5);
            checks++;
            if (gate_en[1] !== eg) begin
                errors++;
                $display("FAIL idle_drain gate_en k=%0d: got %b expected %b", k, gate_en[1], eg);
            end
        end
        step(3);
        checks++;
        if ({gate_en[1], active[1]} !== 2'b00) begin
            errors++;
            $display("FAIL idle_drain off: got %b%b expected 00", gate_en[1], active[1]);
        end
        idle[1] = 1'b0;
        wake_domain(1);
        idle[1] = 1'b1;
        step(3);
        idle[1] = 1'b0;
        step(1);
        idle[1] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            eg = (k <= 5);
            checks++;
            if (gate_en[1] !== eg) begin
                errors++;
                $display("FAIL idle_restart gate_en k=%0d: got %b expected %b", k, gate_en[1], eg);
            end
        end
        idle[1]    = 1'b0;
        auto_en[1] = 1'b0;
        step(4);
    endtask

    task automatic test_force_on;
        force_on[2] = 1'b1;
        idle[2]     = 1'b1;
        auto_en[2]  = 1'b1;
        thresh      = 8'd1;
        step(5);
        for (int k = 0; k < 100; k++) begin
            checks++;
            if ({gate_en[2], active[2]} !== 2'b11) begin
                errors++;
                $display("FAIL force_on cycle %0d: got %b%b expected 11", k, gate_en[2], active[2]);
            end
            step(1);
        end
        force_on[2] = 1'b0;
        step(1);
        checks++;
        if (gate_en[2] !== 1'b1) begin
            errors++;
            $display("FAIL force_release r1 gate_en: got %b expected 1", gate_en[2]);
        end
        step(1);
        checks++;
        if (gate_en[2] !== 1'b0) begin
            errors++;
            $display("FAIL force_release r2 gate_en: got %b expected 0", gate_en[2]);
        end
        idle[2]    = 1'b0;
        auto_en[2] = 1'b0;
        step(4);
    endtask

    task automatic test_drain_wake;
        logic [9:0] exp_g;
        logic [9:0] exp_a;
        exp_g = 10'b1111000011;
        exp_a = 10'b1000000011;
        wake_domain(3);
        auto_en[3] = 1'b1;
        idle[3]    = 1'b1;
        thresh     = 8'd2;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            checks++;
            if (gate_en[3] !== exp_g[k-1]) begin
                errors++;
                $display("FAIL drain_wake gate_en k=%0d: got %b expected %b", k, gate_en[3], exp_g[k-1]);
            end
            checks++;
            if (active[3] !== exp_a[k-1]) begin
                errors++;
                $display("FAIL drain_wake active k=%0d: got %b expected %b", k, active[3], exp_a[k-1]);
            end
            if (k == 3) wake_req[3] = 1'b1;
        end
        wake_req[3] = 1'b0;
        idle[3]     = 1'b0;
        auto_en[3]  = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid_wake;
        wake_req[2] = 1'b1;
        step(1);
        wake_req[2] = 1'b0;
        step(1);
        checks++;
        if (gate_en[2] !== 1'b1) begin
            errors++;
            $display("FAIL mid_wake pre-reset gate_en: got %b expected 1", gate_en[2]);
        end
        rst = 1'b1;
        step(1);
        checks++;
        if ({gate_en, active} !== 8'h00) begin
            errors++;
            $display("FAIL mid_wake reset outputs: got %b %b expected 0000 0000", gate_en, active);
        end
        checks++;
        if (all_off !== 1'b1) begin
            errors++;
            $display("FAIL mid_wake reset all_off: got %b expected 1", all_off);
        end
        rst         = 1'b0;
        wake_req[0] = 1'b1;
        step(1);
        checks++;
        if ({gate_en, all_off} !== 5'b00001) begin
            errors++;
            $display("FAIL release edge1: got %b %b expected 0000 1", gate_en, all_off);
        end
        step(1);
        wake_req[0] = 1'b0;
        checks++;
        if (gate_en !== 4'b0001) begin
            errors++;
            $display("FAIL release edge2 gate_en: got %b expected 0001", gate_en);
        end
    endtask

    task automatic test_thresh;
        step(4);
        auto_en[0] = 1'b1;
        idle[0]    = 1'b1;
        thresh     = 8'd0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            checks++;
            if (gate_en[0] !== 1'b1) begin
                errors++;
                $display("FAIL thresh_zero cycle %0d: got %b expected 1", k, gate_en[0]);
            end
        end
        thresh = 8'd10;
        step(6);
        thresh = 8'd3;
        for (int k = 0; k < 10; k++) begin
            step(1);
            checks++;
            if (gate_en[0] !== 1'b1) begin
                errors++;
                $display("FAIL thresh_drop cycle %0d: got %b expected 1", k, gate_en[0]);
            end
        end
        idle[0] = 1'b0;
        step(1);
        idle[0] = 1'b1;
        step(3);
        checks++;
        if (gate_en[0] !== 1'b1) begin
            errors++;
            $display("FAIL thresh_drop recount e3: got %b expected 1", gate_en[0]);
        end
        step(1);
        checks++;
        if (gate_en[0] !== 1'b0) begin
            errors++;
            $display("FAIL thresh_drop recount e4: got %b expected 0", gate_en[0]);
        end
        idle[0]    = 1'b0;
        auto_en[0] = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        force_on = '0;
        auto_en  = '0;
        wake_req = '0;
        idle     = '0;
        thresh   = '0;
        test_reset;
        test_wake_latency;
        test_idle_drain;
        test_force_on;
        test_drain_wake;
        test_reset_mid_wake;
        test_thresh;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 4: number of independently gated clock domains.
REQ-002 SHALL have parameter IDLE_CNT_W, default 8: width of the idle counter and of idle_thresh_i.
REQ-003 SHALL have parameter SYNC_LAT, default 3, legal range 1..15: cycles allowed for a downstream clock-gate enable to take effect.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is posedge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port force_on_i, input, NUM_DOMAINS bits: per-domain software override that keeps the clock on.
REQ-007 SHALL have port auto_en_i, input, NUM_DOMAINS bits: per-domain permission for idle-based auto gating.
REQ-008 SHALL have port wake_req_i, input, NUM_DOMAINS bits: per-domain hardware wake request, level-sensitive.
REQ-009 SHALL have port idle_i, input, NUM_DOMAINS bits: per-domain "domain idle" status.
REQ-010 SHALL have port idle_thresh_i, input, IDLE_CNT_W bits: consecutive idle cycles before gating; shared by all domains; 0 disables auto gating.
REQ-011 SHALL have port gate_en_o, output, NUM_DOMAINS bits: registered enable driven to each domain's clock gate.
REQ-012 SHALL have port active_o, output, NUM_DOMAINS bits: registered flag, domain clock guaranteed running.
REQ-013 SHALL have port all_off_o, output, 1 bit: registered flag, every domain is in OFF.

Function
REQ-014 SHALL run one independent FSM per domain with states OFF, WAKE, ON and DRAIN.
REQ-015 OFF SHALL drive gate_en=0 and active=0; a cycle with force_on|wake_req SHALL move the FSM to WAKE on the next edge.
REQ-016 WAKE SHALL drive gate_en=1 and active=0, last exactly SYNC_LAT cycles via a down-counter loaded with SYNC_LAT-1 on entry, and move to ON after the counter reads 0.
REQ-017 Wake latency SHALL be: request sampled at edge t gives gate_en_o=1 after edge t+1 and active_o=1 after edge t+1+SYNC_LAT.
REQ-018 ON SHALL drive gate_en=1 and active=1.
REQ-019 In ON, a cycle is qualifying when auto_en & idle & !force_on & !wake_req & (idle_thresh_i!=0).
REQ-020 In ON, each qualifying cycle SHALL increment the idle counter; any non-qualifying cycle SHALL clear it to 0.
REQ-021 In ON, a qualifying cycle with idle_cnt==idle_thresh_i-1 SHALL move the FSM to DRAIN on the next edge, i.e. after exactly idle_thresh_i consecutive qualifying cycles, and SHALL clear the idle counter.
REQ-022 The idle counter SHALL never wrap; with idle_thresh_i=2^IDLE_CNT_W-1 it reaches at most that value minus 1.
REQ-023 A change of idle_thresh_i SHALL take effect on the current comparison and SHALL NOT reset the counter.
REQ-024 If idle_thresh_i drops to or below the current idle count, the FSM SHALL enter DRAIN only if the counter equals the new idle_thresh_i-1; otherwise it SHALL stay in ON until the next non-qualifying cycle clears the counter.
REQ-025 DRAIN SHALL drive gate_en=0 and active=0, last exactly SYNC_LAT cycles, and SHALL NOT be abortable.
REQ-026 A wake_req or force_on that arrives during DRAIN SHALL be honoured from OFF: level held gives OFF for exactly 1 cycle, then WAKE.
REQ-027 When force_on and the idle conditions are present together, force_on SHALL win: no counting and no DRAIN.
REQ-028 Deasserting force_on or wake_req during WAKE SHALL NOT abort the wake; the FSM still reaches ON.
REQ-029 all_off_o SHALL be 1 in the cycle after every FSM is registered OFF, i.e. it lags the state by 1 cycle.

Reset
REQ-030 While rst_i=1 at an edge, every FSM SHALL go to OFF and all counters to 0.
REQ-031 After a reset edge, gate_en_o=0, active_o=0 and all_off_o=1.
REQ-032 Reset mid-WAKE, mid-ON or mid-DRAIN SHALL drop gate_en_o immediately at that edge, with no DRAIN sequencing.
REQ-033 The first edge with rst_i=0 SHALL evaluate normal transitions from OFF.

Structure
REQ-034 Package clk_gate_ctrl_pkg SHALL hold the state enum (OFF, WAKE, ON, DRAIN; 2 bits) and the default SYNC_LAT constant.
REQ-035 Per-domain logic SHALL live in sub-module clk_gate_ctrl_ch, instantiated NUM_DOMAINS times by a generate loop.
REQ-036 The top level SHALL contain only the channel array and the all_off register.
REQ-037 The design SHALL contain no latches and no combinational outputs.

Verification
REQ-038 Reset, then wake_req[0] pulsed for 1 cycle at edge 10 (SYNC_LAT=3) -> gate_en_o[0]=1 from edge 11, active_o[0]=1 from edge 14, all_off_o=0 from edge 12.
REQ-039 Domain 1 in ON, auto_en=1, idle_thresh=5, idle held -> DRAIN entered after exactly 5 idle cycles, OFF 3 cycles later; one non-idle cycle at idle count 3 -> counter restarts and DRAIN is delayed by 4 cycles.
REQ-040 force_on[2]=1 with idle=1, auto_en=1, idle_thresh=1 for 100 cycles -> domain 2 stays ON throughout.
REQ-041 wake_req[3] asserted in the 2nd DRAIN cycle and held -> DRAIN completes, OFF for 1 cycle, WAKE, ON; active_o never glitches high during DRAIN.
REQ-042 rst_i asserted in the 2nd WAKE cycle -> gate_en_o=0 and all_off_o=1 after that edge; idle_thresh=0 with idle held -> domain never gates.
